// File: rtl/pipe_pkg.sv
// Shared types and constants for the MEM/WB pipeline stage and its data-memory handshake.
package pipe_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned REG_IDX_W       = 5;
  localparam int unsigned WAIT_CNT_W      = 8;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } dmem_state_e;

  // Registered request presented to data memory for the whole access.
  typedef struct packed {
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } dmem_cmd_t;

  // MEM/WB pipeline register payload.
  typedef struct packed {
    logic                 wreg;
    logic                 m2reg;
    logic [XLEN-1:0]      mo;
    logic [XLEN-1:0]      alu;
    logic [REG_IDX_W-1:0] rn;
  } mem_wb_t;

  // Memory is word addressed; the byte offset is dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/dmem_access_ctl.sv
// Data-memory handshake FSM: issues one request per memop, waits for ack or
// aborts after TIMEOUT unacknowledged BUSY cycles, and generates the stall.
module dmem_access_ctl
  import pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            mwmem,
  input  logic            mm2reg,
  input  logic [XLEN-1:0] malu,
  input  logic [XLEN-1:0] mb,
  input  logic            dmem_ack,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic            dmem_err,
  output logic            mstall,
  output logic            wb_alu_c,
  output logic            wb_mem_c
);

  // wait_cnt_q holds the number of unacked BUSY cycles already completed; the
  // access is abandoned in the cycle that would bring it up to TIMEOUT.
  localparam logic [WAIT_CNT_W-1:0] LAST_WAIT = WAIT_CNT_W'(TIMEOUT - 1);

  dmem_state_e           state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  dmem_cmd_t             cmd_q, cmd_d;
  logic                  err_q, err_d;
  logic                  memop_c;
  logic [WAIT_CNT_W-1:0] wait_inc_c;

  assign memop_c    = mwmem | mm2reg;
  assign wait_inc_c = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + WAIT_CNT_W'(1);

  // Next-state, counter, request and stall/writeback-select decode.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    cmd_d      = cmd_q;
    err_d      = err_q;
    mstall     = 1'b0;
    wb_alu_c   = 1'b0;
    wb_mem_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (memop_c) begin
          state_d     = ST_BUSY;
          wait_cnt_d  = '0;
          cmd_d.req   = 1'b1;
          cmd_d.we    = mwmem;
          cmd_d.addr  = word_align(malu);
          cmd_d.wdata = mb;
          mstall      = 1'b1;
        end else begin
          wb_alu_c = 1'b1;
        end
      end
      ST_BUSY: begin
        if (dmem_ack) begin
          state_d   = ST_IDLE;
          cmd_d.req = 1'b0;
          wb_mem_c  = 1'b1;
        end else if (wait_cnt_q == LAST_WAIT) begin
          // Abort: instruction retires as a bubble, error is sticky.
          state_d    = ST_IDLE;
          cmd_d.req  = 1'b0;
          err_d      = 1'b1;
          wait_cnt_d = wait_inc_c;
        end else begin
          wait_cnt_d = wait_inc_c;
          mstall     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and memory-request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      cmd_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      cmd_q      <= cmd_d;
      err_q      <= err_d;
    end
  end

  assign dmem_req   = cmd_q.req;
  assign dmem_we    = cmd_q.we;
  assign dmem_addr  = cmd_q.addr;
  assign dmem_wdata = cmd_q.wdata;
  assign dmem_err   = err_q;

endmodule

// File: rtl/pipe_mem_wb_stage.sv
// MEM stage with data-memory handshake and the MEM/WB pipeline register.
module pipe_mem_wb_stage
  import pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic                 mwreg,
  input  logic                 mm2reg,
  input  logic                 mwmem,
  input  logic [XLEN-1:0]      malu,
  input  logic [XLEN-1:0]      mb,
  input  logic [REG_IDX_W-1:0] mrn,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [XLEN-1:0]      dmem_addr,
  output logic [XLEN-1:0]      dmem_wdata,
  input  logic [XLEN-1:0]      dmem_rdata,
  input  logic                 dmem_ack,
  output logic                 mstall,
  output logic                 wwreg,
  output logic                 wm2reg,
  output logic [XLEN-1:0]      wmo,
  output logic [XLEN-1:0]      walu,
  output logic [REG_IDX_W-1:0] wrn,
  output logic                 dmem_err
);

  mem_wb_t mem_wb_q, mem_wb_d;
  logic    wb_alu_c;
  logic    wb_mem_c;

  dmem_access_ctl #(
    .TIMEOUT (TIMEOUT)
  ) u_ctl (
    .clk        (clk),
    .clrn       (clrn),
    .mwmem      (mwmem),
    .mm2reg     (mm2reg),
    .malu       (malu),
    .mb         (mb),
    .dmem_ack   (dmem_ack),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_err   (dmem_err),
    .mstall     (mstall),
    .wb_alu_c   (wb_alu_c),
    .wb_mem_c   (wb_mem_c)
  );

  // MEM/WB next value: bubble by default (stall or abort), otherwise retire.
  always_comb begin
    mem_wb_d       = mem_wb_q;
    mem_wb_d.wreg  = 1'b0;
    mem_wb_d.m2reg = 1'b0;
    if (wb_mem_c) begin
      // A combined load+store is a store; the read data is not written back.
      mem_wb_d.wreg  = mwreg;
      mem_wb_d.m2reg = mm2reg & ~mwmem;
      mem_wb_d.mo    = dmem_rdata;
      mem_wb_d.alu   = malu;
      mem_wb_d.rn    = mrn;
    end else if (wb_alu_c) begin
      mem_wb_d.wreg = mwreg;
      mem_wb_d.alu  = malu;
      mem_wb_d.rn   = mrn;
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      mem_wb_q <= '0;
    end else begin
      mem_wb_q <= mem_wb_d;
    end
  end

  assign wwreg  = mem_wb_q.wreg;
  assign wm2reg = mem_wb_q.m2reg;
  assign wmo    = mem_wb_q.mo;
  assign walu   = mem_wb_q.alu;
  assign wrn    = mem_wb_q.rn;

endmodule

// File: tb/tb_pipe_mem_wb_stage.sv
// Directed bench for pipe_mem_wb_stage with TIMEOUT=4.
module tb_pipe_mem_wb_stage;

  logic        clk;
  logic        clrn;
  logic        mwreg, mm2reg, mwmem;
  logic [31:0] malu, mb;
  logic [4:0]  mrn;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        mstall;
  logic        wwreg, wm2reg;
  logic [31:0] wmo, walu;
  logic [4:0]  wrn;
  logic        dmem_err;

  int n_cmp;
  int n_bad;
  int stalls;

  pipe_mem_wb_stage #(
    .TIMEOUT (4)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .mwreg      (mwreg),
    .mm2reg     (mm2reg),
    .mwmem      (mwmem),
    .malu       (malu),
    .mb         (mb),
    .mrn        (mrn),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .mstall     (mstall),
    .wwreg      (wwreg),
    .wm2reg     (wm2reg),
    .wmo        (wmo),
    .walu       (walu),
    .wrn        (wrn),
    .dmem_err   (dmem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic wr, input logic m2r, input logic wm,
                        input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn);
    mwreg  = wr;
    mm2reg = m2r;
    mwmem  = wm;
    malu   = alu;
    mb     = b;
    mrn    = rn;
  endtask

  task automatic nop();
    set_ex(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  // Sample mstall after inputs settle and tally stall cycles.
  task automatic chk_stall(input string tag, input logic exp);
    #1;
    check_eq(tag, 32'(mstall), 32'(exp));
    if (mstall) stalls++;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    stalls = 0;
    clrn = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    nop();
    tick();
    tick();

    // Reset state
    check_eq("rst_req",   32'(dmem_req), 32'h0);
    check_eq("rst_we",    32'(dmem_we), 32'h0);
    check_eq("rst_addr",  dmem_addr, 32'h0);
    check_eq("rst_wdata", dmem_wdata, 32'h0);
    check_eq("rst_err",   32'(dmem_err), 32'h0);
    check_eq("rst_wwreg", 32'(wwreg), 32'h0);
    check_eq("rst_walu",  walu, 32'h0);
    check_eq("rst_wrn",   32'(wrn), 32'h0);
    check_eq("rst_wmo",   wmo, 32'h0);
    check_eq("rst_stall", 32'(mstall), 32'h0);
    clrn = 1'b1;
    tick();

    // ALU op passes straight through in one cycle
    set_ex(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5);
    chk_stall("alu_stall", 1'b0);
    tick();
    check_eq("alu_wwreg",  32'(wwreg), 32'h1);
    check_eq("alu_wm2reg", 32'(wm2reg), 32'h0);
    check_eq("alu_walu",   walu, 32'h1234);
    check_eq("alu_wrn",    32'(wrn), 32'd5);

    // Load, ack in 4th BUSY cycle (counter at its last value, ack wins)
    stalls = 0;
    set_ex(1'b1, 1'b1, 1'b0, 32'h103, 32'h0, 5'd7);
    chk_stall("ld_stall0", 1'b1);
    check_eq("ld_req0", 32'(dmem_req), 32'h0);
    tick();
    check_eq("ld_req1",  32'(dmem_req), 32'h1);
    check_eq("ld_we1",   32'(dmem_we), 32'h0);
    check_eq("ld_addr1", dmem_addr, 32'h100);
    check_eq("ld_bubble_wwreg", 32'(wwreg), 32'h0);
    check_eq("ld_bubble_walu", walu, 32'h1234);
    chk_stall("ld_stall1", 1'b1);
    tick();
    chk_stall("ld_stall2", 1'b1);
    tick();
    chk_stall("ld_stall3", 1'b1);
    check_eq("ld_addr3", dmem_addr, 32'h100);
    tick();
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    chk_stall("ld_stall4", 1'b0);
    check_eq("ld_stall_count", 32'(stalls), 32'd4);
    tick();
    dmem_ack = 1'b0;
    nop();
    check_eq("ld_wwreg",  32'(wwreg), 32'h1);
    check_eq("ld_wm2reg", 32'(wm2reg), 32'h1);
    check_eq("ld_wmo",    wmo, 32'hDEADBEEF);
    check_eq("ld_wrn",    32'(wrn), 32'd7);
    check_eq("ld_walu",   walu, 32'h103);
    check_eq("ld_req_off", 32'(dmem_req), 32'h0);
    check_eq("ld_no_err", 32'(dmem_err), 32'h0);

    // Store, ack 1 cycle after request
    stalls = 0;
    set_ex(1'b0, 1'b0, 1'b1, 32'h40, 32'hCAFE0001, 5'd9);
    chk_stall("st_stall0", 1'b1);
    tick();
    check_eq("st_req",   32'(dmem_req), 32'h1);
    check_eq("st_we",    32'(dmem_we), 32'h1);
    check_eq("st_wdata", dmem_wdata, 32'hCAFE0001);
    check_eq("st_addr",  dmem_addr, 32'h40);
    check_eq("st_wwreg1", 32'(wwreg), 32'h0);
    chk_stall("st_stall1", 1'b1);
    tick();
    dmem_ack = 1'b1;
    dmem_rdata = 32'h11111111;
    chk_stall("st_stall2", 1'b0);
    check_eq("st_stall_count", 32'(stalls), 32'd2);
    tick();
    dmem_ack = 1'b0;
    nop();
    check_eq("st_wwreg2", 32'(wwreg), 32'h0);
    check_eq("st_wm2reg", 32'(wm2reg), 32'h0);
    check_eq("st_wmo",    wmo, 32'h11111111);
    check_eq("st_req_off", 32'(dmem_req), 32'h0);

    // Load that never gets acked: abort after 4 BUSY cycles
    set_ex(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 5'd3);
    chk_stall("to_stall0", 1'b1);
    tick();
    chk_stall("to_stall1", 1'b1);
    tick();
    chk_stall("to_stall2", 1'b1);
    tick();
    chk_stall("to_stall3", 1'b1);
    check_eq("to_err_early", 32'(dmem_err), 32'h0);
    tick();
    chk_stall("to_stall4", 1'b0);
    check_eq("to_req4", 32'(dmem_req), 32'h1);
    tick();
    nop();
    check_eq("to_err",   32'(dmem_err), 32'h1);
    check_eq("to_req",   32'(dmem_req), 32'h0);
    check_eq("to_wwreg", 32'(wwreg), 32'h0);
    check_eq("to_wrn_kept", 32'(wrn), 32'd9);
    chk_stall("to_stall5", 1'b0);

    // Two back-to-back loads, ack in first BUSY cycle each
    set_ex(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd10);
    chk_stall("b2b_stall_a0", 1'b1);
    tick();
    check_eq("b2b_addr_a", dmem_addr, 32'h300);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hA1A1A1A1;
    chk_stall("b2b_stall_a1", 1'b0);
    tick();
    dmem_ack = 1'b0;
    set_ex(1'b1, 1'b1, 1'b0, 32'h304, 32'h0, 5'd11);
    check_eq("b2b_wrn_a", 32'(wrn), 32'd10);
    check_eq("b2b_wmo_a", wmo, 32'hA1A1A1A1);
    check_eq("b2b_wwreg_a", 32'(wwreg), 32'h1);
    chk_stall("b2b_stall_b0", 1'b1);
    tick();
    check_eq("b2b_req_b", 32'(dmem_req), 32'h1);
    check_eq("b2b_addr_b", dmem_addr, 32'h304);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hB2B2B2B2;
    tick();
    dmem_ack = 1'b0;
    check_eq("b2b_wrn_b", 32'(wrn), 32'd11);
    check_eq("b2b_wmo_b", wmo, 32'hB2B2B2B2);

    // Ack while IDLE with a non-memop is ignored
    set_ex(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 5'd2);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h99999999;
    chk_stall("idle_ack_stall", 1'b0);
    tick();
    dmem_ack = 1'b0;
    nop();
    check_eq("idle_ack_walu", walu, 32'h55);
    check_eq("idle_ack_wmo",  wmo, 32'hB2B2B2B2);
    check_eq("idle_ack_req",  32'(dmem_req), 32'h0);
    check_eq("err_sticky",    32'(dmem_err), 32'h1);

    // Load+store together behaves as a store, no load writeback
    set_ex(1'b1, 1'b1, 1'b1, 32'h406, 32'h77, 5'd12);
    chk_stall("ls_stall0", 1'b1);
    tick();
    check_eq("ls_we",   32'(dmem_we), 32'h1);
    check_eq("ls_addr", dmem_addr, 32'h404);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hAAAAAAAA;
    tick();
    dmem_ack = 1'b0;
    nop();
    check_eq("ls_wm2reg", 32'(wm2reg), 32'h0);
    check_eq("ls_wwreg",  32'(wwreg), 32'h1);

    // Reset in the middle of an access, then a late ack
    set_ex(1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 5'd4);
    tick();
    check_eq("mr_req", 32'(dmem_req), 32'h1);
    clrn = 1'b0;
    nop();
    tick();
    clrn = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'h12345678;
    #1;
    check_eq("mr_req_off", 32'(dmem_req), 32'h0);
    check_eq("mr_stall",   32'(mstall), 32'h0);
    check_eq("mr_err_clr", 32'(dmem_err), 32'h0);
    check_eq("mr_addr",    dmem_addr, 32'h0);
    tick();
    dmem_ack = 1'b0;
    check_eq("mr_wwreg", 32'(wwreg), 32'h0);
    check_eq("mr_wmo",   wmo, 32'h0);
    check_eq("mr_walu",  walu, 32'h0);
    check_eq("mr_wrn",   32'(wrn), 32'h0);
    check_eq("mr_req2",  32'(dmem_req), 32'h0);
    check_eq("mr_we",    32'(dmem_we), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_mem_wb_stage.md
PIPE_MEM_WB_STAGE -- requirements
Module: pipe_mem_wb_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max BUSY cycles before abort (1..255).
REQ-002 SHALL have ports clk  in  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have ports clrn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have inputs mwreg, mm2reg, mwmem  in  1 each  EX/MEM control: regfile write, load, store.
REQ-005 SHALL have inputs malu  in  32  address/ALU result; mb  in  32  store data; mrn  in  5  dest reg.
REQ-006 SHALL have outputs dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32; dmem_wdata  out  32.
REQ-007 SHALL have inputs dmem_rdata  in  32; dmem_ack  in  1  memory completion strobe.
REQ-008 SHALL have output mstall  out  1  hold EX/MEM and earlier stages this cycle.
REQ-009 SHALL have outputs wwreg, wm2reg  out  1 each; wmo  out  32; walu  out  32; wrn  out  5  MEM/WB register.
REQ-010 SHALL have output dmem_err  out  1  sticky timeout flag.

Function
REQ-011 memop = mwmem | mm2reg; mwmem and mm2reg both 1 is treated as store (dmem_we=1), load data discarded.
REQ-012 FSM states IDLE, BUSY; IDLE & memop -> BUSY; BUSY & dmem_ack -> IDLE; BUSY & wait count == TIMEOUT -> IDLE.
REQ-013 On IDLE->BUSY edge: register dmem_req=1, dmem_we=mwmem, dmem_addr={malu[31:2],2'b00}, dmem_wdata=mb.
REQ-014 dmem_req, dmem_we, dmem_addr, dmem_wdata SHALL hold stable throughout BUSY; dmem_req=0 in IDLE.
REQ-015 mstall (combinational) = (IDLE & memop) | (BUSY & ~dmem_ack & ~timeout).
REQ-016 dmem_ack SHALL be ignored in IDLE; ack is sampled earliest first BUSY cycle (min access latency 1 cycle after request).
REQ-017 Non-memop in IDLE: MEM/WB loads wwreg=mwreg, wm2reg=0, walu=malu, wrn=mrn, wmo unchanged; latency 1 cycle.
REQ-018 BUSY & dmem_ack: MEM/WB loads wwreg=mwreg, wm2reg=mm2reg & ~mwmem, wmo=dmem_rdata, walu=malu, wrn=mrn.
REQ-019 Any cycle with mstall=1: MEM/WB SHALL load a bubble (wwreg=0, wm2reg=0; data fields unchanged).
REQ-020 8-bit wait counter clears on entry to BUSY, increments each BUSY cycle without ack, saturates.
REQ-021 Timeout: set dmem_err=1, drop dmem_req, load bubble into MEM/WB, mstall=0 (instruction retires as no-op).
REQ-022 Ack in same cycle counter reaches TIMEOUT: ack wins, no error.
REQ-023 Back-to-back memops: after ack cycle, next IDLE cycle with memop re-enters BUSY; no idle cycle inserted on dmem_req beyond 1.

Reset
REQ-024 clrn=0 at posedge clk: state=IDLE, counter=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_err=0, wwreg=0, wm2reg=0, wmo=0, walu=0, wrn=0.
REQ-025 Reset mid-BUSY SHALL abandon access; dmem_req=0 next cycle; late dmem_ack after reset ignored.
REQ-026 dmem_err cleared only by reset.

Structure
REQ-027 FSM state encoding and TIMEOUT default SHALL live in shared package pipe_pkg.
REQ-028 Memory handshake FSM plus counter SHALL be sub-module dmem_access_ctl; MEM/WB register stays in top.

Verification
REQ-029 ALU op: mwreg=1, malu=0x1234, mrn=5 -> next cycle wwreg=1, walu=0x1234, wrn=5, mstall never 1.
REQ-030 Load, ack 3 cycles after request, rdata=0xDEADBEEF, malu=0x103 -> dmem_addr=0x100, mstall 4 cycles, then wwreg=1, wm2reg=1, wmo=0xDEADBEEF.
REQ-031 Store mb=0xCAFE0001, malu=0x40, ack 1 cycle -> dmem_we=1, dmem_wdata=0xCAFE0001, wwreg=0 throughout, mstall 2 cycles.
REQ-032 Load, no ack, TIMEOUT=4 -> dmem_err=1 after 4 BUSY cycles, dmem_req=0, mstall=0, bubble in MEM/WB.
REQ-033 clrn=0 during BUSY then ack pulse one cycle later -> all outputs 0, state IDLE, no MEM/WB write.
REQ-034 Two consecutive loads, ack 1 cycle each -> two distinct requests, two writebacks, wrn order preserved.
